// File: rtl/p2_vector_sequencer_if.sv
// Stimulus/response bundle between the vector sequencer and its environment.
// The sequencer drives the P2 inputs and reports sweep status; the environment drives start/abort and f.
interface p2_vector_sequencer_if;
    logic       start;
    logic       abort;
    logic       f;
    logic       a;
    logic       b;
    logic       c;
    logic [2:0] step;
    logic       busy;
    logic       done;
    logic [7:0] truth_table;

    modport master (
        input  start, abort, f,
        output a, b, c, step, busy, done, truth_table
    );

    modport slave (
        output start, abort, f,
        input  a, b, c, step, busy, done, truth_table
    );
endinterface

// File: rtl/p2_vector_sequencer.sv
// Gray-code stimulus sweep around the P2 3-input function: holds each vector for
// HOLD_CYCLES cycles, samples f at the end of each hold and builds an 8-bit truth table.
module p2_vector_sequencer #(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    p2_vector_sequencer_if.master   bus
);

    localparam int unsigned STEP_W = 3;
    localparam int unsigned TT_W   = 8;

    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(7);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q,  step_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [STEP_W-1:0]   abc_q,   abc_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;
    logic [TT_W-1:0]     tt_q,    tt_d;
    logic                hold_end;
    logic                last_step;

    function automatic logic [STEP_W-1:0] gray(input logic [STEP_W-1:0] s);
        return s ^ (s >> 1);
    endfunction

    assign hold_end  = (cnt_q == HOLD_LAST);
    assign last_step = (step_q == LAST_STEP);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
            abc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tt_q    <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            abc_q   <= abc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tt_q    <= tt_d;
        end
    end

    // Next-state logic; abort outranks the final capture
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = DRIVE;
            end
            DRIVE: begin
                if (bus.abort)                  state_d = IDLE;
                else if (hold_end && last_step) state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and hold counter
    always_comb begin
        step_d = step_q;
        cnt_d  = cnt_q;
        abc_d  = abc_q;
        busy_d = busy_q;
        done_d = 1'b0;
        tt_d   = tt_q;
        case (state_q)
            IDLE: begin
                abc_d  = '0;
                step_d = '0;
                cnt_d  = '0;
                busy_d = 1'b0;
                if (bus.start) begin
                    busy_d = 1'b1;
                    tt_d   = '0;
                end
            end
            DRIVE: begin
                if (bus.abort) begin
                    abc_d  = '0;
                    step_d = '0;
                    cnt_d  = '0;
                    busy_d = 1'b0;
                end else if (hold_end) begin
                    // Capture is indexed by the minterm on the pins, not by sweep position
                    tt_d[abc_q] = bus.f;
                    cnt_d       = '0;
                    if (last_step) begin
                        abc_d  = '0;
                        step_d = '0;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                        abc_d  = gray(step_q + STEP_W'(1));
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FINISH: begin
                abc_d  = '0;
                step_d = '0;
                cnt_d  = '0;
                busy_d = 1'b0;
            end
            default: begin
                abc_d  = '0;
                step_d = '0;
                cnt_d  = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.a           = abc_q[2];
    assign bus.b           = abc_q[1];
    assign bus.c           = abc_q[0];
    assign bus.step        = step_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.truth_table = tt_q;

endmodule

// File: tb/tb_p2_vector_sequencer.sv
// Bench for p2_vector_sequencer: two instances (hold 10 and hold 1) swept against
// truth tables generated from the expected Boolean functions and from random tables.
module tb_p2_vector_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] fn10, fn1;
    logic       gl10, gl1;

    p2_vector_sequencer_if i10 ();
    p2_vector_sequencer_if i1  ();

    // Behavioural P2 stand-in: table lookup, optionally disturbed away from capture points
    assign i10.f = fn10[{i10.a, i10.b, i10.c}] ^ gl10;
    assign i1.f  = fn1[{i1.a, i1.b, i1.c}] ^ gl1;

    p2_vector_sequencer #(.HOLD_CYCLES(10), .CNT_W(4)) dut10 (
        .clk(clk), .rst_n(rst_n), .bus(i10.master));
    p2_vector_sequencer #(.HOLD_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(i1.master));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] o_abc(input bit s);
        return s ? {i1.a, i1.b, i1.c} : {i10.a, i10.b, i10.c};
    endfunction
    function automatic logic [2:0] o_step(input bit s);
        return s ? i1.step : i10.step;
    endfunction
    function automatic logic o_busy(input bit s);
        return s ? i1.busy : i10.busy;
    endfunction
    function automatic logic o_done(input bit s);
        return s ? i1.done : i10.done;
    endfunction
    function automatic logic [7:0] o_tt(input bit s);
        return s ? i1.truth_table : i10.truth_table;
    endfunction

    task automatic drv_start(input bit s, input logic v);
        if (s) i1.start = v; else i10.start = v;
    endtask
    task automatic drv_abort(input bit s, input logic v);
        if (s) i1.abort = v; else i10.abort = v;
    endtask
    task automatic drv_gl(input bit s, input logic v);
        if (s) gl1 = v; else gl10 = v;
    endtask

    function automatic logic [7:0] tbl_ab_or_c();
        logic [7:0] t;
        for (int k = 0; k < 8; k++) t[k] = (k[2] & k[1]) | k[0];
        return t;
    endfunction
    function automatic logic [7:0] tbl_xor3();
        logic [7:0] t;
        for (int k = 0; k < 8; k++) t[k] = k[2] ^ k[1] ^ k[0];
        return t;
    endfunction

    task automatic check_idle(input bit s, input logic [7:0] tt_exp, input string tag);
        chk({tag, "_abc"},  32'(o_abc(s)),  32'd0);
        chk({tag, "_step"}, 32'(o_step(s)), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy(s)), 32'd0);
        chk({tag, "_done"}, 32'(o_done(s)), 32'd0);
        chk({tag, "_tt"},   32'(o_tt(s)),   32'(tt_exp));
    endtask

    // One sweep: start pulse, per-cycle expectations from vector index = (cycle-1)/h
    task automatic sweep(input bit s, input int h, input logic [7:0] fn,
                         input int abort_cyc, input bit extra_start, input bit start_with_abort);
        logic [2:0] prev, cur;
        logic [7:0] exp_tt;
        if (s) fn1 = fn; else fn10 = fn;
        drv_start(s, 1'b1);
        drv_abort(s, start_with_abort);
        @(posedge clk); #1;
        drv_start(s, 1'b0);
        drv_abort(s, 1'b0);
        chk("tt_cleared", 32'(o_tt(s)), 32'd0);
        prev = 3'b000;
        for (int j = 1; j <= 8 * h; j++) begin
            int v;
            int pos;
            v   = (j - 1) / h;
            pos = (j - 1) % h;
            cur = o_abc(s);
            chk("abc",  32'(cur),       32'(v ^ (v >> 1)));
            chk("step", 32'(o_step(s)), 32'(v));
            chk("busy", 32'(o_busy(s)), 32'd1);
            chk("done_early", 32'(o_done(s)), 32'd0);
            if (j > 1) chk("gray_toggle", 32'($countones(cur ^ prev)), (pos == 0) ? 32'd1 : 32'd0);
            prev = cur;
            drv_gl(s, (pos != h - 1) ? 1'($urandom) : 1'b0);
            drv_start(s, extra_start && v == 2 && pos == 0);
            drv_abort(s, j == abort_cyc);
            @(posedge clk); #1;
            drv_gl(s, 1'b0);
            drv_start(s, 1'b0);
            drv_abort(s, 1'b0);
            if (j == abort_cyc) begin
                exp_tt = 8'h00;
                for (int k = 0; k < 8; k++)
                    if ((k + 1) * h < j) exp_tt[k ^ (k >> 1)] = fn[k ^ (k >> 1)];
                check_idle(s, exp_tt, "abort");
                repeat (3) begin
                    @(posedge clk); #1;
                    check_idle(s, exp_tt, "post_abort");
                end
                return;
            end
        end
        chk("done_pulse", 32'(o_done(s)), 32'd1);
        chk("fin_busy",   32'(o_busy(s)), 32'd0);
        chk("fin_abc",    32'(o_abc(s)),  32'd0);
        chk("fin_step",   32'(o_step(s)), 32'd0);
        chk("fin_tt",     32'(o_tt(s)),   32'(fn));
        if (extra_start) drv_start(s, 1'b1);
        @(posedge clk); #1;
        drv_start(s, 1'b0);
        check_idle(s, fn, "after_done");
        @(posedge clk); #1;
        check_idle(s, fn, "idle_hold");
    endtask

    initial begin
        i10.start = 1'b0; i10.abort = 1'b0;
        i1.start  = 1'b0; i1.abort  = 1'b0;
        fn10 = 8'h00; fn1 = 8'h00; gl10 = 1'b0; gl1 = 1'b0;
        rst_n = 1'b0;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        check_idle(1'b0, 8'h00, "in_reset10");
        check_idle(1'b1, 8'h00, "in_reset1");
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check_idle(1'b0, 8'h00, "idle10");
            check_idle(1'b1, 8'h00, "idle1");
        end

        // Full sweeps on both hold settings
        sweep(1'b0, 10, tbl_ab_or_c(), -1, 1'b0, 1'b0);
        sweep(1'b1, 1,  tbl_xor3(),    -1, 1'b0, 1'b0);

        // Abort in the 5th cycle of the third vector, then a clean sweep
        sweep(1'b0, 10, tbl_ab_or_c(), 25, 1'b0, 1'b0);
        sweep(1'b0, 10, tbl_ab_or_c(), -1, 1'b0, 1'b0);

        // Abort coinciding with the final capture
        sweep(1'b1, 1, 8'($urandom), 8, 1'b0, 1'b0);
        sweep(1'b0, 10, 8'($urandom), 80, 1'b0, 1'b0);

        // Start while busy is ignored
        sweep(1'b0, 10, tbl_ab_or_c(), -1, 1'b1, 1'b0);
        sweep(1'b1, 1, 8'($urandom), -1, 1'b1, 1'b0);

        // Start and abort together in IDLE: start wins
        sweep(1'b1, 1, 8'($urandom), -1, 1'b0, 1'b1);

        // Abort in IDLE is ignored and leaves the table alone
        i1.abort = 1'b1;
        @(posedge clk); #1;
        i1.abort = 1'b0;
        check_idle(1'b1, fn1, "idle_abort");

        // Asynchronous reset mid-sweep at step 5
        fn10 = 8'($urandom);
        i10.start = 1'b1;
        @(posedge clk); #1;
        i10.start = 1'b0;
        repeat (52) @(posedge clk);
        #1;
        chk("pre_reset_step", 32'(i10.step), 32'd5);
        chk("pre_reset_busy", 32'(i10.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle(1'b0, 8'h00, "async_rst10");
        check_idle(1'b1, 8'h00, "async_rst1");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        check_idle(1'b0, 8'h00, "rst_release");
        sweep(1'b0, 10, tbl_ab_or_c(), -1, 1'b0, 1'b0);

        // Randomized sweeps with optional random abort point
        for (int r = 0; r < 8; r++) begin
            bit s;
            int h;
            int ab;
            s  = 1'($urandom);
            h  = s ? 1 : 10;
            ab = ($urandom % 2 == 0) ? -1 : int'($urandom_range(8 * h, 1));
            sweep(s, h, 8'($urandom), ab, 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
